// File: rtl/regfile_mp.sv
// regfile_mp: 2R/2W register file with optional zero register, write->read bypass,
// sequential bulk-clear engine and registered debug tap.
module regfile_mp #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [DW-1:0] wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd1,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1,
  input  logic          clr_req,
  output logic          busy,
  input  logic [AW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_data
);
  localparam int DEPTH = 1 << AW;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] ptr;
  logic [DW-1:0] mem [DEPTH];
  logic acc0, acc1;
  assign busy = state == CLEAR;
  assign acc0 = we0 && !busy && !(ZERO_R0 != 0 && wa0 == '0);
  assign acc1 = we1 && !busy && !(ZERO_R0 != 0 && wa1 == '0);
  // Port 1 is checked first so it wins both the bypass and the same-address store.
  function automatic logic [DW-1:0] rdata(input logic [AW-1:0] ra);
    return (ZERO_R0 != 0 && ra == '0) ? '0 :
           (BYPASS != 0 && acc1 && wa1 == ra) ? wd1 :
           (BYPASS != 0 && acc0 && wa0 == ra) ? wd0 : mem[ra];
  endfunction
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = clr_req ? CLEAR : IDLE;
    else state_nxt = (ptr == AW'(DEPTH - 1)) ? IDLE : CLEAR;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
    end else begin
      state <= state_nxt;
      ptr <= busy ? ptr + AW'(1) : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (busy) begin
      mem[ptr] <= '0;
    end else begin
      if (acc0) mem[wa0] <= wd0;
      if (acc1) mem[wa1] <= wd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd0 <= '0;
      rd1 <= '0;
      dbg_data <= '0;
    end else begin
      rd0 <= rdata(ra0);
      rd1 <= rdata(ra1);
      dbg_data <= mem[dbg_sel];
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors against a bypassing zero-r0 instance and a
// plain (no bypass, writable entry 0) instance sharing the same stimulus.
module tb_regfile_mp;
  logic clk = 0;
  logic rst_n, we0, we1, clr_req;
  logic [4:0] wa0, wa1, ra0, ra1, dbg_sel;
  logic [31:0] wd0, wd1;
  logic [31:0] rd0, rd1, dbg_data, nb_rd0, nb_rd1, nb_dbg;
  logic busy, nb_busy;
  int vectors = 0, errors = 0, cnt;

  always #5 clk = ~clk;

  regfile_mp #(.DW(32), .AW(5), .ZERO_R0(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1),
    .wd1(wd1), .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1), .clr_req(clr_req),
    .busy(busy), .dbg_sel(dbg_sel), .dbg_data(dbg_data));

  regfile_mp #(.DW(32), .AW(5), .ZERO_R0(0), .BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1),
    .wd1(wd1), .ra0(ra0), .ra1(ra1), .rd0(nb_rd0), .rd1(nb_rd1), .clr_req(clr_req),
    .busy(nb_busy), .dbg_sel(dbg_sel), .dbg_data(nb_dbg));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; we0 = 0; we1 = 0; clr_req = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; ra0 = 0; ra1 = 0; dbg_sel = 0;
    tick(); tick();
    chk("rst_rd0", rd0, 0);
    chk("rst_rd1", rd1, 0);
    chk("rst_dbg", dbg_data, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    rst_n = 1;
    tick();

    we0 = 1; wa0 = 2; wd0 = 32'h123; ra1 = 2;
    tick();
    chk("byp_rd1", rd1, 32'h123);
    chk("nobyp_rd1", nb_rd1, 0);
    we0 = 0; ra0 = 2; dbg_sel = 2;
    tick();
    chk("rd0_a2", rd0, 32'h123);
    chk("nb_rd0_a2", nb_rd0, 32'h123);
    chk("dbg_a2", dbg_data, 32'h123);

    #2 rst_n = 0;
    #1;
    chk("async_rd0", rd0, 0);
    chk("async_rd1", rd1, 0);
    chk("async_dbg", dbg_data, 0);
    chk("async_busy", {31'b0, busy}, 0);
    rst_n = 1;
    tick();
    chk("a2_cleared", rd0, 0);

    we0 = 1; wa0 = 4; wd0 = 32'hAAAA; we1 = 1; wa1 = 4; wd1 = 32'h5555;
    ra0 = 4; dbg_sel = 4;
    tick();
    chk("dual_byp", rd0, 32'h5555);
    chk("dual_nobyp", nb_rd0, 0);
    we0 = 0; we1 = 0;
    tick();
    chk("dual_dbg", dbg_data, 32'h5555);
    chk("dual_nb_rd0", nb_rd0, 32'h5555);

    we0 = 1; wa0 = 5; wd0 = 32'h11; we1 = 1; wa1 = 6; wd1 = 32'h22; ra0 = 5; ra1 = 6;
    tick();
    chk("split_rd0", rd0, 32'h11);
    chk("split_rd1", rd1, 32'h22);
    we0 = 0; we1 = 0;
    tick();
    chk("split_nb_rd0", nb_rd0, 32'h11);
    chk("split_nb_rd1", nb_rd1, 32'h22);

    we0 = 1; wa0 = 0; wd0 = 32'hFFFF_FFFF; ra0 = 0; dbg_sel = 0;
    tick();
    chk("r0_byp", rd0, 0);
    chk("r0_nb_pre", nb_rd0, 0);
    we0 = 0;
    tick();
    chk("r0_later", rd0, 0);
    chk("r0_nb_later", nb_rd0, 32'hFFFF_FFFF);
    chk("r0_dbg", dbg_data, 0);

    for (int i = 1; i < 32; i++) begin
      we0 = 1; wa0 = 5'(i); wd0 = i;
      tick();
    end
    we0 = 0; ra0 = 17; ra1 = 31;
    tick();
    chk("fill_rd0", rd0, 17);
    chk("fill_rd1", rd1, 31);

    clr_req = 1;
    tick();
    clr_req = 0;
    chk("clr_busy", {31'b0, busy}, 1);
    cnt = 1;
    ra0 = 9; ra1 = 20;
    for (int i = 0; i < 40; i++) begin
      we0 = i < 5; wa0 = 9; wd0 = 32'h999;
      clr_req = i == 3;
      tick();
      if (busy) cnt++;
      if (i == 5) chk("clr_partial", rd1, 20);
    end
    we0 = 0; clr_req = 0;
    chk("busy_len", cnt, 32);
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a); dbg_sel = 5'(a);
      tick();
      chk($sformatf("clr_rd0_%0d", a), rd0, 0);
      chk($sformatf("clr_dbg_%0d", a), dbg_data, 0);
    end

    we0 = 1; wa0 = 25; wd0 = 32'h77;
    tick();
    we0 = 0; clr_req = 1;
    tick();
    clr_req = 0;
    repeat (9) tick();
    chk("mid_busy", {31'b0, busy}, 1);
    #2 rst_n = 0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 0);
    rst_n = 1;
    tick();
    chk("midrst_busy2", {31'b0, busy}, 0);
    ra0 = 25;
    tick();
    chk("midrst_a25", rd0, 0);
    we0 = 1; wa0 = 3; wd0 = 32'h33;
    tick();
    we0 = 0; ra0 = 3;
    tick();
    chk("post_wr", rd0, 32'h33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
